seq_detect_param: RTL and testbench

Parametrised serial bit-sequence detector. It compares a gated serial input against a runtime-programmable pattern of PATTERN_LEN bits and pulses a match flag on each detection. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits in the lab datapath as the general replacement for fixed-pattern, fixed-length sequence checkers.

---
 rtl/seq_detect_param.sv | 144 ++++++++++++++
 tb/tb_seq_detect_param.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial bit-sequence detector with a runtime-programmable MSB-first pattern,
// overlap/non-overlap detection and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned                PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0]     PATTERN_RST = '0,
  parameter bit                         OVERLAP_RST = 1'b1,
  parameter int unsigned                CNT_W       = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic                               in,
  input  logic                               cfg_load,
  input  logic [PATTERN_LEN-1:0]             cfg_pattern,
  input  logic                               cfg_overlap,
  input  logic                               cnt_clr,
  output logic                               match,
  output logic [CNT_W-1:0]                   match_cnt,
  output logic                               cnt_sat,
  output logic [$clog2(PATTERN_LEN+1)-1:0]   fill
);

  localparam int unsigned FILL_W = $clog2(PATTERN_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_FILLING = 2'd0,
    S_ARMED   = 2'd1,
    S_RESTART = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PATTERN_LEN-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [PATTERN_LEN-1:0]  pattern_q, pattern_d;
  logic                    overlap_q, overlap_d;
  logic                    match_q, match_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q, sat_d;

  logic                    accept;
  logic [PATTERN_LEN-1:0]  hist_shift;
  logic [FILL_W-1:0]       fill_inc;
  logic [PATTERN_LEN-1:0]  bit_eq;
  logic                    hit;

  // cfg_load wins over in_valid: the bit presented alongside a reload is dropped.
  assign accept     = in_valid & ~cfg_load;
  assign hist_shift = {hist_q[PATTERN_LEN-2:0], in};
  assign fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < PATTERN_LEN; gi++) begin : g_cmp
      assign bit_eq[gi] = ~(hist_shift[gi] ^ pattern_q[gi]);
    end
  endgenerate

  assign hit = accept && (fill_inc == FILL_FULL) && (&bit_eq);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILLING;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    case (state_q)
      S_FILLING, S_ARMED, S_RESTART: begin
        if (cfg_load) begin
          pattern_d = cfg_pattern;
          overlap_d = cfg_overlap;
          hist_d    = '0;
          fill_d    = '0;
          state_d   = S_FILLING;
        end else if (accept) begin
          hist_d = hist_shift;
          if (hit && !overlap_q) begin
            // Non-overlap: the next detection must be built from N fresh bits.
            fill_d  = '0;
            state_d = S_RESTART;
          end else begin
            fill_d  = fill_inc;
            state_d = (fill_inc == FILL_FULL) ? S_ARMED : S_FILLING;
          end
        end else if (state_q == S_RESTART) begin
          state_d = S_FILLING;
        end
      end
      default: begin
        state_d = S_FILLING;
        fill_d  = '0;
      end
    endcase
  end

  // Output logic: match pulse and saturating counter
  always_comb begin
    match_d = hit;
    cnt_d   = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    sat_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= PATTERN_RST;
      overlap_q <= OVERLAP_RST;
      match_q   <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: expected outputs are queued as each
// input is driven and compared one cycle later against the registered outputs.
module tb_seq_detect_param;

  localparam int N = 4;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in;
  logic             cfg_load;
  logic [N-1:0]     cfg_pattern;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             match;
  logic [CW-1:0]    match_cnt;
  logic             cnt_sat;
  logic [2:0]       fill;

  seq_detect_param #(
    .PATTERN_LEN (N),
    .PATTERN_RST (4'b0000),
    .OVERLAP_RST (1'b1),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in          (in),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .match_cnt   (match_cnt),
    .cnt_sat     (cnt_sat),
    .fill        (fill)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          m;
    logic [CW-1:0] c;
    logic          s;
    logic [2:0]    f;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [N-1:0]  m_hist;
  int            m_fill;
  logic [N-1:0]  m_pat;
  logic          m_ov;
  int            m_cnt;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_hist = '0;
    m_fill = 0;
    m_pat  = 4'b0000;
    m_ov   = 1'b1;
    m_cnt  = 0;
  endtask

  task automatic step(input string tag, input logic v, input logic b, input logic ld,
                      input logic [N-1:0] pat, input logic ov, input logic clr);
    logic hit;
    exp_t e;
    hit = 1'b0;
    if (ld) begin
      m_pat  = pat;
      m_ov   = ov;
      m_hist = '0;
      m_fill = 0;
    end else if (v) begin
      m_hist = {m_hist[N-2:0], b};
      if (m_fill < N) m_fill++;
      hit = (m_fill == N) && (m_hist == m_pat);
      if (hit && !m_ov) m_fill = 0;
    end
    if (clr) m_cnt = 0;
    else if (hit && m_cnt != (1 << CW) - 1) m_cnt++;
    e.m = hit;
    e.c = CW'(m_cnt);
    e.s = (m_cnt == (1 << CW) - 1);
    e.f = 3'(m_fill);
    exp_q.push_back(e);

    in_valid    = v;
    in          = b;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_overlap = ov;
    cnt_clr     = clr;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".match"}, 8'(match), 8'(e.m));
    check({tag, ".cnt"},   8'(match_cnt), 8'(e.c));
    check({tag, ".sat"},   8'(cnt_sat), 8'(e.s));
    check({tag, ".fill"},  8'(fill), 8'(e.f));
    $display("%-6s v=%0b in=%0b ld=%0b clr=%0b -> match=%0b cnt=%0d sat=%0b fill=%0d",
             tag, v, b, ld, clr, match, match_cnt, cnt_sat, fill);
  endtask

  task automatic feed(input string tag, input logic b);
    step(tag, 1'b1, b, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag, input logic b);
    step(tag, 1'b0, b, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic load(input string tag, input logic [N-1:0] pat, input logic ov,
                      input logic v, input logic b);
    step(tag, v, b, 1'b1, pat, ov, 1'b0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, n_vec=%0d", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    #12;
    check("rst.match", 8'(match), 8'd0);
    check("rst.cnt",   8'(match_cnt), 8'd0);
    check("rst.sat",   8'(cnt_sat), 8'd0);
    check("rst.fill",  8'(fill), 8'd0);
    rst = 1'b0;
    model_reset();

    // 1: default pattern 0000, overlapping
    for (int i = 0; i < 6; i++) feed("t1", 1'b0);
    feed("t1", 1'b1);
    feed("t1", 1'b0);
    check("t1.cnt_total", 8'(match_cnt), 8'd3);
    check("t1.fill_full", 8'(fill), 8'd4);

    // 2: 1010 non-overlap, then overlap
    load("t2ld", 4'b1010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) feed("t2a", (i % 2 == 0) ? 1'b1 : 1'b0);
    check("t2.cnt_nonovl", 8'(match_cnt), 8'd4);
    load("t2ld", 4'b1010, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) feed("t2b", (i % 2 == 0) ? 1'b1 : 1'b0);
    check("t2.cnt_ovl", 8'(match_cnt), 8'd6);

    // 3: in_valid gap while in toggles
    load("t3ld", 4'b1010, 1'b1, 1'b0, 1'b0);
    feed("t3", 1'b1);
    feed("t3", 1'b0);
    idle("t3gap", 1'b1);
    idle("t3gap", 1'b0);
    idle("t3gap", 1'b1);
    check("t3.fill_hold", 8'(fill), 8'd2);
    feed("t3", 1'b1);
    feed("t3", 1'b0);
    check("t3.match", 8'(match), 8'd1);

    // 4: reload with a would-be completing bit present
    load("t4ld", 4'b1010, 1'b1, 1'b0, 1'b0);
    feed("t4", 1'b1);
    feed("t4", 1'b0);
    feed("t4", 1'b1);
    load("t4ld2", 4'b1010, 1'b1, 1'b1, 1'b0);
    check("t4.dropped", 8'(match), 8'd0);
    feed("t4", 1'b1);
    feed("t4", 1'b0);
    feed("t4", 1'b1);
    feed("t4", 1'b0);
    check("t4.match", 8'(match), 8'd1);

    // 5: saturation, then clear coincident with a match
    step("t5clr", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    load("t5ld", 4'b0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) feed("t5", 1'b0);
    check("t5.cnt_sat_val", 8'(match_cnt), 8'd15);
    check("t5.sat_flag", 8'(cnt_sat), 8'd1);
    step("t5clm", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    check("t5.clr_match", 8'(match), 8'd1);
    check("t5.clr_cnt", 8'(match_cnt), 8'd0);

    // 6: asynchronous reset mid-pattern
    feed("t6", 1'b0);
    load("t6ld", 4'b1010, 1'b0, 1'b0, 1'b0);
    feed("t6", 1'b1);
    feed("t6", 1'b0);
    feed("t6", 1'b1);
    in_valid = 1'b0; in = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6.async_fill", 8'(fill), 8'd0);
    check("t6.async_match", 8'(match), 8'd0);
    check("t6.async_cnt", 8'(match_cnt), 8'd0);
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) feed("t6r", 1'b0);
    check("t6.no_early", 8'(match), 8'd0);
    feed("t6r", 1'b0);
    check("t6.match", 8'(match), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
